posit4_mac_seq: RTL and testbench
=================================

// Module: posit4_mac_seq
// PURPOSE
//  Dot-product sequencer for the posit4 MAC datapath. It accepts a job (vector length, precision, exponent floor).
//  It then streams act/w pairs from an upstream valid/ready source into the MAC one operation at a time.
//  The MAC's fixed-point/exponent result is chained back as the next accumulator input.
//  It returns the final sum over a valid/ready result port. Sits between the activation/weight buffers and fp_posit4_mac.
// PARAMETERS
//  ACT_WIDTH    16  activation width, passed through to the MAC
//  ACC_WIDTH    32  accumulator width, must match the MAC
//  LEN_WIDTH    8   width of vector-length field (max job length 2**LEN_WIDTH-1)
//  WDOG_CYCLES  64  max cycles waiting for mac_done (only with POSIT4_MAC_SEQ_WDOG_EN)
// PORTS
//  clk              in   1          clock
//  rst              in   1          asynchronous active-high reset
//  start            in   1          job request; sampled only in IDLE
//  vec_len          in   LEN_WIDTH  number of MAC ops in the job
//  precision        in   4          precision code forwarded to MAC
//  exp_min          in   5          exponent floor forwarded to MAC; initial exp_out for empty jobs
//  busy             out  1          high in every state except IDLE
//  in_valid         in   1          act/w pair valid
//  in_ready         out  1          sequencer accepts pair (ISSUE state only)
//  in_act           in   ACT_WIDTH  activation
//  in_w             in   4          posit4 weight
//  mac_valid        out  1          one-cycle issue pulse to MAC
//  mac_set          out  1          high with mac_valid on first element of a job
//  mac_precision    out  4          latched precision
//  mac_act          out  ACT_WIDTH  registered activation
//  mac_w            out  4          registered weight
//  mac_exp_min      out  5          latched exp_min
//  mac_acc          out  ACC_WIDTH  running accumulator fed to MAC fixed_point_acc
//  mac_done         in   1          MAC completion pulse
//  mac_exp_out      in   5          MAC exponent result
//  mac_acc_out      in   ACC_WIDTH  MAC fixed-point result
//  mac_nar          in   1          MAC NaR flag
//  res_valid        out  1          result valid, held until res_ready
//  res_ready        in   1          result consumer ready
//  res_acc          out  ACC_WIDTH  final fixed-point sum
//  res_exp          out  5          final exponent
//  res_nar          out  1          sticky NaR for the job
//  res_timeout      out  1          watchdog fired (tied 0 without WDOG_EN)
// BEHAVIOUR
//  Reset: all outputs and registers 0; state IDLE. Reset mid-job aborts the job; no result is produced.
//  FSM: IDLE -> (start & vec_len!=0) ISSUE; IDLE -> (start & vec_len==0) OUT with res_acc=0, res_exp=exp_min.
//  On start, latch vec_len/precision/exp_min and clear acc_q, cnt, and the nar flag.
//  ISSUE: in_ready=1. On in_valid, register act/w, pulse mac_valid for 1 cycle (mac_set=1 iff cnt==0), -> WAIT.
//  WAIT: in_ready=0. On mac_done: acc_q<=mac_acc_out, exp_q<=mac_exp_out, nar|=mac_nar, cnt++.
//    Then -> OUT if cnt==vec_len-1, else -> ISSUE.
//  OUT: res_valid=1, results stable; on res_ready -> IDLE (no bubble; start is sampled the following cycle).
//  Exactly one MAC op outstanding. Per-element cost = 1 issue cycle + MAC latency.
//  mac_done outside WAIT is ignored. start outside IDLE is ignored.
//  NaR: the job continues consuming all vec_len pairs (upstream stays aligned); res_nar=1 and res_acc as chained.
//  cnt is LEN_WIDTH bits; vec_len = 2**LEN_WIDTH-1 completes without wrap.
// CONFIGURATION
//  POSIT4_MAC_SEQ_WDOG_EN defined: a counter runs in WAIT and clears on mac_done.
//    On reaching WDOG_CYCLES it goes -> OUT with res_timeout=1 and res_nar=1; the remaining pairs are NOT consumed.
//  Undefined: no counter; WAIT lasts indefinitely; res_timeout tied 0.
// STRUCTURE
//  Package posit4_mac_pkg: FSM state encoding (IDLE, ISSUE, WAIT, OUT), posit4 NaR code 4'b1000, exponent width 5.
//  Sub-module posit4_seq_wdog (counter + fire flag), instantiated only under the macro. FSM and datapath stay in this file.
// TESTING
//  Bench MAC stub: fixed latency 3; mac_acc_out=mac_acc+1; mac_exp_out=mac_exp_min; mac_nar when w==4'b1000.
//  vec_len=4, in_valid always high -> 4 mac_valid pulses, mac_set only on 1st, res_acc=4, res_exp=exp_min, busy 16 cycles.
//  vec_len=0, exp_min=5'd7 -> no mac_valid, res_valid 1 cycle after start, res_acc=0, res_exp=7.
//  vec_len=3, 2nd w=4'b1000 -> 3 ops issued, res_nar=1, res_acc=3; next job res_nar=0.
//  in_valid gapped (pair every 5 cycles), res_ready held low 10 cycles -> res_valid/res_acc stable throughout, no extra issue.
//  rst asserted in WAIT of a vec_len=8 job -> immediate IDLE, all outputs 0, late mac_done ignored; new job vec_len=2 gives res_acc=2.
//  WDOG_EN, WDOG_CYCLES=64, stub never asserts done -> res_timeout=1 and res_nar=1 exactly 64 cycles after issue.

Source files
------------

// File: rtl/posit4_mac_pkg.sv
// Shared definitions for the posit4 MAC sequencer: FSM state encoding,
// posit4 NaR code and exponent field width.
package posit4_mac_pkg;

  localparam int EXP_W = 5;

  localparam logic [3:0] POSIT4_NAR = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/posit4_seq_wdog.sv
// Watchdog for the MAC sequencer: counts cycles spent waiting for mac_done
// and raises fire on the CYCLES-th waiting cycle.
module posit4_seq_wdog #(
  parameter int CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic fire
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt_q;

  // cnt_q holds (waiting cycles - 1), so fire lands exactly on cycle CYCLES.
  assign fire = run && !clr && (cnt_q == CW'(CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!run || clr) begin
      cnt_q <= '0;
    end else if (!fire) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/posit4_mac_seq.sv
// Dot-product sequencer for the posit4 MAC: issues one act/w pair at a time and
// chains the MAC result back as the next accumulator. Optional watchdog: POSIT4_MAC_SEQ_WDOG_EN.
module posit4_mac_seq
  import posit4_mac_pkg::*;
#(
  parameter int ACT_WIDTH   = 16,
  parameter int ACC_WIDTH   = 32,
  parameter int LEN_WIDTH   = 8,
  parameter int WDOG_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] vec_len,
  input  logic [3:0]           precision,
  input  logic [EXP_W-1:0]     exp_min,
  output logic                 busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ACT_WIDTH-1:0] in_act,
  input  logic [3:0]           in_w,
  output logic                 mac_valid,
  output logic                 mac_set,
  output logic [3:0]           mac_precision,
  output logic [ACT_WIDTH-1:0] mac_act,
  output logic [3:0]           mac_w,
  output logic [EXP_W-1:0]     mac_exp_min,
  output logic [ACC_WIDTH-1:0] mac_acc,
  input  logic                 mac_done,
  input  logic [EXP_W-1:0]     mac_exp_out,
  input  logic [ACC_WIDTH-1:0] mac_acc_out,
  input  logic                 mac_nar,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ACC_WIDTH-1:0] res_acc,
  output logic [EXP_W-1:0]     res_exp,
  output logic                 res_nar,
  output logic                 res_timeout
);

  seq_state_e           state_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] cnt_q;
  logic [3:0]           prec_q;
  logic [EXP_W-1:0]     emin_q;
  logic [ACT_WIDTH-1:0] act_q;
  logic [3:0]           w_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [EXP_W-1:0]     exp_q;
  logic                 nar_q;
  logic                 timeout_q;
  logic                 mac_valid_q;
  logic                 mac_set_q;
  logic                 busy_q;
  logic                 in_ready_q;
  logic                 res_valid_q;
  logic                 wdog_fire;

`ifdef POSIT4_MAC_SEQ_WDOG_EN
  posit4_seq_wdog #(
    .CYCLES (WDOG_CYCLES)
  ) u_wdog (
    .clk  (clk),
    .rst  (rst),
    .run  (state_q == ST_WAIT),
    .clr  (mac_done),
    .fire (wdog_fire)
  );
`else
  logic unused_wdog_cfg;
  assign unused_wdog_cfg = (WDOG_CYCLES != 0);
  assign wdog_fire       = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      prec_q      <= '0;
      emin_q      <= '0;
      act_q       <= '0;
      w_q         <= '0;
      acc_q       <= '0;
      exp_q       <= '0;
      nar_q       <= 1'b0;
      timeout_q   <= 1'b0;
      mac_valid_q <= 1'b0;
      mac_set_q   <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every branch
      // below reads the pre-edge values of all registers, independent of order.
      mac_valid_q <= 1'b0;
      mac_set_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            len_q     <= vec_len;
            prec_q    <= precision;
            emin_q    <= exp_min;
            acc_q     <= '0;
            exp_q     <= exp_min;
            cnt_q     <= '0;
            nar_q     <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b1;
            if (vec_len == '0) begin
              state_q     <= ST_OUT;
              res_valid_q <= 1'b1;
            end else begin
              state_q    <= ST_ISSUE;
              in_ready_q <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (in_valid) begin
            act_q       <= in_act;
            w_q         <= in_w;
            mac_valid_q <= 1'b1;
            mac_set_q   <= (cnt_q == '0);
            in_ready_q  <= 1'b0;
            state_q     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mac_done) begin
            acc_q <= mac_acc_out;
            exp_q <= mac_exp_out;
            nar_q <= nar_q | mac_nar;
            cnt_q <= cnt_q + LEN_WIDTH'(1);
            // len_q is non-zero here, so the last-element compare cannot wrap.
            if (cnt_q == len_q - LEN_WIDTH'(1)) begin
              state_q     <= ST_OUT;
              res_valid_q <= 1'b1;
            end else begin
              state_q    <= ST_ISSUE;
              in_ready_q <= 1'b1;
            end
          end else if (wdog_fire) begin
            // Abandon the job; unconsumed pairs stay with the upstream source.
            timeout_q   <= 1'b1;
            nar_q       <= 1'b1;
            state_q     <= ST_OUT;
            res_valid_q <= 1'b1;
          end
        end
        ST_OUT: begin
          if (res_ready) begin
            state_q     <= ST_IDLE;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign in_ready      = in_ready_q;
  assign mac_valid     = mac_valid_q;
  assign mac_set       = mac_set_q;
  assign mac_precision = prec_q;
  assign mac_act       = act_q;
  assign mac_w         = w_q;
  assign mac_exp_min   = emin_q;
  assign mac_acc       = acc_q;
  assign res_valid     = res_valid_q;
  assign res_acc       = acc_q;
  assign res_exp       = exp_q;
  assign res_nar       = nar_q;
  assign res_timeout   = timeout_q;

endmodule

// File: tb/tb_posit4_mac_seq.sv
// Self-checking bench for posit4_mac_seq with a latency-3 MAC stub and a result scoreboard.
`timescale 1ns/1ps
module tb_posit4_mac_seq;
  import posit4_mac_pkg::*;

  localparam int ACT_WIDTH = 16;
  localparam int ACC_WIDTH = 32;
  localparam int LEN_WIDTH = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [LEN_WIDTH-1:0] vec_len = '0;
  logic [3:0]           precision = '0;
  logic [EXP_W-1:0]     exp_min = '0;
  logic                 busy;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [ACT_WIDTH-1:0] in_act = '0;
  logic [3:0]           in_w = '0;
  logic                 mac_valid, mac_set;
  logic [3:0]           mac_precision, mac_w;
  logic [ACT_WIDTH-1:0] mac_act;
  logic [EXP_W-1:0]     mac_exp_min;
  logic [ACC_WIDTH-1:0] mac_acc;
  logic                 mac_done;
  logic [EXP_W-1:0]     mac_exp_out;
  logic [ACC_WIDTH-1:0] mac_acc_out;
  logic                 mac_nar;
  logic                 res_valid;
  logic                 res_ready = 1'b0;
  logic [ACC_WIDTH-1:0] res_acc;
  logic [EXP_W-1:0]     res_exp;
  logic                 res_nar, res_timeout;

  posit4_mac_seq #(
    .ACT_WIDTH (ACT_WIDTH), .ACC_WIDTH (ACC_WIDTH), .LEN_WIDTH (LEN_WIDTH), .WDOG_CYCLES (64)
  ) dut (
    .clk (clk), .rst (rst), .start (start), .vec_len (vec_len), .precision (precision),
    .exp_min (exp_min), .busy (busy), .in_valid (in_valid), .in_ready (in_ready),
    .in_act (in_act), .in_w (in_w), .mac_valid (mac_valid), .mac_set (mac_set),
    .mac_precision (mac_precision), .mac_act (mac_act), .mac_w (mac_w),
    .mac_exp_min (mac_exp_min), .mac_acc (mac_acc), .mac_done (mac_done),
    .mac_exp_out (mac_exp_out), .mac_acc_out (mac_acc_out), .mac_nar (mac_nar),
    .res_valid (res_valid), .res_ready (res_ready), .res_acc (res_acc), .res_exp (res_exp),
    .res_nar (res_nar), .res_timeout (res_timeout)
  );

  always #5 clk = ~clk;

  // MAC stub: done two cycles after the mac_valid cycle (3 edges after issue).
  logic                 stub_mute = 1'b0;
  logic [1:0]           pipe_v = '0;
  logic [ACC_WIDTH-1:0] p0_acc = '0, p1_acc = '0;
  logic [EXP_W-1:0]     p0_exp = '0, p1_exp = '0;
  logic                 p0_nar = 1'b0, p1_nar = 1'b0;

  always @(posedge clk) begin
    pipe_v <= {pipe_v[0], mac_valid & ~stub_mute};
    p0_acc <= mac_acc + 32'd1;
    p0_exp <= mac_exp_min;
    p0_nar <= (mac_w == POSIT4_NAR);
    p1_acc <= p0_acc;
    p1_exp <= p0_exp;
    p1_nar <= p0_nar;
  end

  assign mac_done    = pipe_v[1];
  assign mac_acc_out = p1_acc;
  assign mac_exp_out = p1_exp;
  assign mac_nar     = p1_nar;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Monitor: issue counting, mac_set placement, busy-before-result cycles.
  int issue_cnt  = 0;
  int job_issue  = 0;
  int busy_nores = 0;

  always @(negedge clk) begin
    if (start && !busy) job_issue = 0;
    if (busy && !res_valid) busy_nores++;
    if (mac_valid) begin
      check("mac_set_first_only", mac_set, (job_issue == 0));
      issue_cnt++;
      job_issue++;
    end
  end

  typedef struct {
    logic [ACC_WIDTH-1:0] acc;
    logic [EXP_W-1:0]     exp;
    logic                 nar;
    logic [3:0]           prec;
  } exp_res_t;

  exp_res_t sb[$];

  task automatic start_job(input int len, input logic [3:0] prec, input logic [EXP_W-1:0] emin);
    @(posedge clk); #1;
    start = 1'b1; vec_len = LEN_WIDTH'(len); precision = prec; exp_min = emin;
    @(negedge clk);
    check("idle_before_start", busy, 1'b0);
    @(posedge clk); #1;
    start = 1'b0; vec_len = '0; precision = '0; exp_min = '0;
  endtask

  task automatic send_pair(input logic [ACT_WIDTH-1:0] act, input logic [3:0] w, input int gap);
    bit taken = 0;
    repeat (gap) @(posedge clk);
    #1;
    in_valid = 1'b1; in_act = act; in_w = w;
    for (int k = 0; k < 200 && !taken; k++) begin
      @(negedge clk);
      if (in_ready) taken = 1;
    end
    if (!taken) check("pair_accept_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic collect(input int hold);
    bit seen = 0;
    int i0;
    logic [ACC_WIDTH-1:0] acc0;
    exp_res_t e;
    for (int k = 0; k < 2000 && !seen; k++) begin
      @(negedge clk);
      if (res_valid) seen = 1;
    end
    if (!seen) begin
      check("res_valid_timeout", 1'b0, 1'b1);
      return;
    end
    acc0 = res_acc;
    i0   = issue_cnt;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_res_valid", res_valid, 1'b1);
      check("hold_res_acc", res_acc, acc0);
    end
    if (hold > 0) check("hold_no_issue", issue_cnt - i0, 0);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1'b1, 1'b0);
    end else begin
      e = sb.pop_front();
      check("res_acc", res_acc, e.acc);
      check("res_exp", res_exp, e.exp);
      check("res_nar", res_nar, e.nar);
      check("res_timeout", res_timeout, 1'b0);
      check("mac_precision", mac_precision, e.prec);
      check("mac_exp_min", mac_exp_min, e.exp);
    end
    @(posedge clk); #1; res_ready = 1'b1;
    @(posedge clk); #1; res_ready = 1'b0;
    @(negedge clk);
    check("res_valid_dropped", res_valid, 1'b0);
    check("idle_after_result", busy, 1'b0);
  endtask

  int last_busy;

  task automatic run_job(input int len, input logic [EXP_W-1:0] emin, input int nar_idx,
                         input int gap, input int hold);
    exp_res_t e;
    int i0, b0;
    e.acc  = ACC_WIDTH'(len);
    e.exp  = emin;
    e.nar  = (nar_idx >= 0 && nar_idx < len);
    e.prec = 4'(len + 3);
    sb.push_back(e);
    i0 = issue_cnt;
    b0 = busy_nores;
    start_job(len, e.prec, emin);
    for (int i = 0; i < len; i++)
      send_pair(16'($urandom), (i == nar_idx) ? POSIT4_NAR : 4'($urandom_range(0, 7)), gap);
    collect(hold);
    check("issue_count", issue_cnt - i0, len);
    last_busy = busy_nores - b0;
  endtask

  initial begin
    int i0;
    // Reset state
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_mac_valid", mac_valid, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_acc", res_acc, '0);
    check("rst_res_timeout", res_timeout, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back 4-element job: 4 x (1 issue + 3 MAC) cycles before the result.
    run_job(4, 5'd9, -1, 0, 0);
    check("busy_cycles_len4", last_busy, 16);

    // Empty job: result the cycle after start, no MAC traffic.
    i0 = issue_cnt;
    sb.push_back('{acc: '0, exp: 5'd7, nar: 1'b0, prec: 4'd3});
    start_job(0, 4'd3, 5'd7);
    check("empty_res_valid_next_cycle", res_valid, 1'b1);
    collect(0);
    check("empty_no_issue", issue_cnt - i0, 0);

    // NaR weight in the middle still consumes all pairs; the next job is clean.
    run_job(3, 5'd4, 1, 0, 0);
    run_job(2, 5'd12, -1, 0, 0);

    // Gapped upstream and a slow consumer.
    run_job(3, 5'd30, -1, 4, 10);

    // Reset while waiting on the MAC aborts the job; the late done is ignored.
    start_job(8, 4'd2, 5'd5);
    send_pair(16'h1234, 4'd3, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_res_valid", res_valid, 1'b0);
    check("abort_mac_acc", mac_acc, '0);
    check("abort_mac_precision", mac_precision, '0);
    check("abort_mac_exp_min", mac_exp_min, '0);
    check("abort_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    i0 = issue_cnt;
    repeat (5) @(negedge clk);
    check("late_done_ignored_busy", busy, 1'b0);
    check("late_done_ignored_valid", res_valid, 1'b0);
    check("late_done_no_issue", issue_cnt - i0, 0);
    run_job(2, 5'd1, -1, 0, 0);

    // Longest job: counter reaches 2**LEN_WIDTH-1 without wrapping.
    run_job(255, 5'd17, -1, 0, 0);

`ifdef POSIT4_MAC_SEQ_WDOG_EN
    begin
      int n;
      bit seen;
      stub_mute = 1'b1;
      i0 = issue_cnt;
      start_job(3, 4'd1, 5'd2);
      send_pair(16'h00ff, 4'd2, 0);
      n = 0; seen = 0;
      for (int k = 0; k < 200 && !seen; k++) begin
        @(negedge clk);
        n++;
        if (res_valid) seen = 1;
      end
      check("wdog_fired", seen, 1'b1);
      check("wdog_latency", n - 1, 64);
      check("wdog_timeout", res_timeout, 1'b1);
      check("wdog_nar", res_nar, 1'b1);
      check("wdog_one_issue", issue_cnt - i0, 1);
      @(posedge clk); #1; res_ready = 1'b1;
      @(posedge clk); #1; res_ready = 1'b0;
      stub_mute = 1'b0;
      @(negedge clk);
      check("wdog_idle", busy, 1'b0);
    end
`endif

    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
